// File: rtl/nd_2to1.sv
// Two-input merge node: per-input FIFOs feeding one four-phase output channel.
// Define ND_2TO1_RR_ARB_EN for round-robin arbitration; otherwise input 0 has fixed priority.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif

module nd_2to1 #(
    parameter int unsigned ASZ  = `NS_ADDRESS_SIZE,
    parameter int unsigned DSZ  = `NS_DATA_SIZE,
    parameter int unsigned FLG2 = 2
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic           snd0_req,
    input  logic           snd0_ack,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic           rcv1_req,
    output logic           rcv1_ack
);
    localparam int unsigned DEPTH = 1 << FLG2;

    typedef logic [ASZ+DSZ-1:0] msg_t;
    typedef logic [FLG2-1:0]    ptr_t;
    typedef logic [FLG2:0]      cnt_t;
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t     state_q, state_d;
    msg_t       mem_q [2][DEPTH];
    ptr_t       wp_q [2], wp_d [2], rp_q [2], rp_d [2];
    cnt_t       cnt_q [2], cnt_d [2];
    logic [1:0] ack_q, ack_d, push, pop, req;
    msg_t       rcv_msg [2];
    msg_t       snd_msg_q, snd_msg_d;
    logic       snd_req_q, snd_req_d;
    logic       run, pop_en, sel;
`ifdef ND_2TO1_RR_ARB_EN
    logic       arb_q, arb_d;
`endif

    always_comb begin
        state_d    = ST_RUN;
        run        = (state_q == ST_RUN);
        req        = {rcv1_req, rcv0_req};
        rcv_msg[0] = {rcv0_dst, rcv0_dat};
        rcv_msg[1] = {rcv1_dst, rcv1_dat};
        pop_en     = run && !snd_req_q && !snd0_ack && ((cnt_q[0] != '0) || (cnt_q[1] != '0));
`ifdef ND_2TO1_RR_ARB_EN
        // arb_q names the preferred input; it only matters when both FIFOs hold data
        sel   = (cnt_q[1] != '0) && ((cnt_q[0] == '0) || arb_q);
        arb_d = pop_en ? !sel : arb_q;
`else
        sel   = (cnt_q[0] == '0);
`endif
        pop[0] = pop_en && !sel;
        pop[1] = pop_en && sel;

        snd_req_d = snd_req_q;
        snd_msg_d = snd_msg_q;
        if (pop_en) begin
            snd_req_d = 1'b1;
            snd_msg_d = mem_q[sel][rp_q[sel]];
        end else if (snd_req_q && snd0_ack) begin
            snd_req_d = 1'b0;
        end

        for (int unsigned n = 0; n < 2; n++) begin
            // full check uses the registered count, so a same-edge pop never frees a slot early
            push[n]  = run && req[n] && !ack_q[n] && (cnt_q[n] < cnt_t'(DEPTH));
            ack_d[n] = ack_q[n];
            if (push[n])
                ack_d[n] = 1'b1;
            else if (!req[n] && ack_q[n])
                ack_d[n] = 1'b0;
            wp_d[n]  = wp_q[n] + ptr_t'(push[n]);
            rp_d[n]  = rp_q[n] + ptr_t'(pop[n]);
            cnt_d[n] = cnt_q[n] + cnt_t'(push[n]) - cnt_t'(pop[n]);
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            ack_q     <= '0;
            snd_req_q <= 1'b0;
            snd_msg_q <= '0;
            for (int unsigned n = 0; n < 2; n++) begin
                wp_q[n]  <= '0;
                rp_q[n]  <= '0;
                cnt_q[n] <= '0;
            end
`ifdef ND_2TO1_RR_ARB_EN
            arb_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            snd_req_q <= snd_req_d;
            snd_msg_q <= snd_msg_d;
            for (int unsigned n = 0; n < 2; n++) begin
                wp_q[n]  <= wp_d[n];
                rp_q[n]  <= rp_d[n];
                cnt_q[n] <= cnt_d[n];
            end
`ifdef ND_2TO1_RR_ARB_EN
            arb_q <= arb_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned n = 0; n < 2; n++)
            if (push[n])
                mem_q[n][wp_q[n]] <= rcv_msg[n];
    end

    assign ready                = (state_q == ST_RUN);
    assign snd0_req             = snd_req_q;
    assign {snd0_dst, snd0_dat} = snd_msg_q;
    assign rcv0_ack             = ack_q[0];
    assign rcv1_ack             = ack_q[1];
endmodule

// File: tb/tb_nd_2to1.sv
// Scoreboard bench for nd_2to1: expected messages queued at drive time, checked as snd0 presents them.
module tb_nd_2to1;
    localparam int unsigned ASZ = 8;
    localparam int unsigned DSZ = 16;

    logic           i_clk = 1'b0;
    logic           reset = 1'b1;
    logic           ready;
    logic [ASZ-1:0] snd0_dst;
    logic [DSZ-1:0] snd0_dat;
    logic           snd0_req;
    logic           snd0_ack = 1'b0;
    logic [ASZ-1:0] rcv0_dst = '0;
    logic [DSZ-1:0] rcv0_dat = '0;
    logic           rcv0_req = 1'b0;
    logic           rcv0_ack;
    logic [ASZ-1:0] rcv1_dst = '0;
    logic [DSZ-1:0] rcv1_dat = '0;
    logic           rcv1_req = 1'b0;
    logic           rcv1_ack;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [ASZ+DSZ-1:0] exp_q [$];
    bit ack_en   = 1'b0;
    bit rand_dly = 1'b0;

    nd_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .FLG2(2)) dut (
        .i_clk(i_clk), .reset(reset), .ready(ready),
        .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_req(snd0_req), .snd0_ack(snd0_ack),
        .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
        .rcv1_dst(rcv1_dst), .rcv1_dat(rcv1_dat), .rcv1_req(rcv1_req), .rcv1_ack(rcv1_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input int unsigned ch, input logic [ASZ-1:0] dst,
                        input logic [DSZ-1:0] dat, input bit sb);
        int c;
        if (sb) exp_q.push_back({dst, dat});
        if (ch == 0) begin rcv0_dst = dst; rcv0_dat = dat; rcv0_req = 1'b1; end
        else         begin rcv1_dst = dst; rcv1_dat = dat; rcv1_req = 1'b1; end
        c = 0;
        do begin @(negedge i_clk); c++; end
        while (!(ch == 0 ? rcv0_ack : rcv1_ack) && c < 300);
        if (c >= 300) chk("ack_up_timeout", 0, 1);
        if (ch == 0) rcv0_req = 1'b0; else rcv1_req = 1'b0;
        c = 0;
        do begin @(negedge i_clk); c++; end
        while ((ch == 0 ? rcv0_ack : rcv1_ack) && c < 300);
        if (c >= 300) chk("ack_down_timeout", 1, 0);
    endtask

    task automatic drain();
        int c = 0;
        ack_en = 1'b1;
        while ((exp_q.size() != 0 || snd0_req || snd0_ack) && c < 1000) begin
            @(negedge i_clk);
            c++;
        end
        if (c >= 1000) chk("drain_timeout", 64'(exp_q.size()), 0);
        ack_en = 1'b0;
    endtask

    // output-side responder: compare the presented message against the scoreboard head
    initial begin
        logic [ASZ+DSZ-1:0] e;
        forever begin
            @(negedge i_clk);
            if (ack_en && snd0_req && !snd0_ack) begin
                if (exp_q.size() == 0) chk("unexpected_out", {snd0_dst, snd0_dat}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_msg", {snd0_dst, snd0_dat}, e);
                end
                if (rand_dly) repeat ($urandom_range(0, 3)) @(negedge i_clk);
                snd0_ack = 1'b1;
                for (int c = 0; c < 50 && snd0_req; c++) @(negedge i_clk);
                if (snd0_req) chk("req_down_timeout", 1, 0);
                snd0_ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ASZ+DSZ-1:0] c_in0 [3];
        logic [ASZ+DSZ-1:0] c_in1 [3];
        int c;

        // reset and init
        repeat (2) @(negedge i_clk);
        chk("rst_ready", ready, 0);
        chk("rst_snd_req", snd0_req, 0);
        chk("rst_snd_msg", {snd0_dst, snd0_dat}, 0);
        chk("rst_acks", {rcv1_ack, rcv0_ack}, 0);
        reset = 1'b0;
        #1 chk("init_pre_ready", ready, 0);
        @(negedge i_clk);
        chk("init_ready", ready, 1);

        // reset asserted mid-handshake discards everything
        rcv0_dst = 8'h11; rcv0_dat = 16'h1111; rcv0_req = 1'b1;
        rcv1_dst = 8'h22; rcv1_dat = 16'h2222; rcv1_req = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("mr_pre_busy", {snd0_req, rcv1_ack, rcv0_ack}, 3'b111);
        #2 reset = 1'b1;
        #1;
        chk("mr_ready", ready, 0);
        chk("mr_snd", {snd0_req, snd0_dst, snd0_dat}, 0);
        chk("mr_acks", {rcv1_ack, rcv0_ack}, 0);
        rcv0_req = 1'b0; rcv1_req = 1'b0;
        @(negedge i_clk);
        reset = 1'b0;
        #1 chk("mr_init_pre", ready, 0);
        @(negedge i_clk);
        chk("mr_init_ready", ready, 1);

        // single path latency
        exp_q.push_back({8'd3, 16'h0055});
        rcv0_dst = 8'd3; rcv0_dat = 16'h0055; rcv0_req = 1'b1;
        @(negedge i_clk);
        chk("sp_ack_k", rcv0_ack, 1);
        chk("sp_req_k", snd0_req, 0);
        @(negedge i_clk);
        chk("sp_req_k1", snd0_req, 1);
        chk("sp_msg", {snd0_dst, snd0_dat}, {8'd3, 16'h0055});
        rcv0_req = 1'b0;
        drain();
        chk("sp_ack_low", rcv0_ack, 0);

        // backpressure: output register occupied, FIFO 1 takes exactly four
        send(0, 8'hA0, 16'h1000, 1'b1);
        repeat (2) @(negedge i_clk);
        chk("bp_out_busy", snd0_req, 1);
        for (int i = 0; i < 4; i++) send(1, 8'(8'hB0 + i), 16'(16'h2000 + i), 1'b1);
        exp_q.push_back({8'hB4, 16'h2004});
        rcv1_dst = 8'hB4; rcv1_dat = 16'h2004; rcv1_req = 1'b1;
        repeat (10) @(negedge i_clk);
        chk("bp_hold", rcv1_ack, 0);
        ack_en = 1'b1;
        c = 0;
        while (!rcv1_ack && c < 100) begin @(negedge i_clk); c++; end
        chk("bp_release", rcv1_ack, 1);
        rcv1_req = 1'b0;
        drain();

        // contention: both inputs queue three while output is held
        for (int i = 0; i < 3; i++) begin
            c_in0[i] = {8'(8'hC0 + i), 16'(16'h3000 + i)};
            c_in1[i] = {8'(8'hD0 + i), 16'(16'h4000 + i)};
        end
`ifdef ND_2TO1_RR_ARB_EN
        for (int i = 0; i < 3; i++) begin exp_q.push_back(c_in0[i]); exp_q.push_back(c_in1[i]); end
`else
        for (int i = 0; i < 3; i++) exp_q.push_back(c_in0[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back(c_in1[i]);
`endif
        fork
            for (int i = 0; i < 3; i++) send(0, c_in0[i][ASZ+DSZ-1:DSZ], c_in0[i][DSZ-1:0], 1'b0);
            for (int i = 0; i < 3; i++) send(1, c_in1[i][ASZ+DSZ-1:DSZ], c_in1[i][DSZ-1:0], 1'b0);
        join
        drain();

        // wrap: ten through input 0 with random output delays
        rand_dly = 1'b1;
        ack_en   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(0, 8'(i), 16'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
        drain();
        repeat (5) @(negedge i_clk);
        chk("final_idle", {snd0_req, rcv1_ack, rcv0_ack}, 0);
        chk("sb_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
